dmem_access_ctrl: RTL and testbench

- Data-memory access controller downstream of the single-cycle MIPS datapath's memory port.
- Turns the datapath's combinational mem_ren/mem_wen/mem_addr/mem_dout request into a registered req/ack bus transaction to a variable-latency data memory.
- Returns read data on mem_din.
- Raises mem_stall so the top level holds cpu_en low until the access completes.

---
 rtl/dmem_access_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns the datapath's combinational memory request
// into a registered req/ack bus transaction. Optional bus timeout: DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access in flight; a request stalls the CPU and is captured
// BUSY  | bus_req high, waiting for bus_ack (or timeout)
// DONE  | access complete, mem_din valid, CPU advances this cycle
module dmem_access_ctrl #(
   parameter int ADDR_W = 32
`ifdef DMEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic              clk,
   input  logic              cpu_rst_n,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_dout,
   output logic [31:0]       mem_din,
   output logic              mem_stall,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              misalign,
   output logic [31:0]       access_cnt
`ifdef DMEM_TIMEOUT_EN
   ,
   output logic              bus_timeout
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   logic   rw_both;

`ifdef DMEM_TIMEOUT_EN
   logic [15:0] wait_cnt;
`endif

   // Stall is combinational so the datapath is held in the request cycle itself.
   assign mem_stall = cpu_rst_n &
                      ((state == BUSY) | ((state == IDLE) & (mem_ren | mem_wen)));

   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state      <= IDLE;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         mem_din    <= '0;
         misalign   <= 1'b0;
         access_cnt <= '0;
         rw_both    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         wait_cnt    <= '0;
         bus_timeout <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (mem_ren | mem_wen) begin
                  bus_we    <= mem_wen;
                  bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                  bus_wdata <= mem_dout;
                  bus_req   <= 1'b1;
                  rw_both   <= mem_ren & mem_wen;
                  if (mem_addr[1:0] != 2'b00) misalign <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (bus_req && bus_ack) begin
                  // A combined read+write is performed as a write and returns zero.
                  if (!bus_we)      mem_din <= bus_rdata;
                  else if (rw_both) mem_din <= '0;
                  bus_req    <= 1'b0;
                  access_cnt <= access_cnt + 32'd1;
                  state      <= DONE;
               end
`ifdef DMEM_TIMEOUT_EN
               else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  if (!bus_we) mem_din <= 32'hDEAD_BEEF;
                  bus_req     <= 1'b0;
                  bus_timeout <= 1'b1;
                  state       <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl; outputs are sampled 1 time
// unit after the rising edge, inputs are driven at the same point.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        cpu_rst_n;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_addr, mem_dout;
   logic [31:0] mem_din;
   logic        mem_stall;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        misalign;
   logic [31:0] access_cnt;
`ifdef DMEM_TIMEOUT_EN
   logic        bus_timeout;
`endif

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DMEM_TIMEOUT_EN
   dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
`else
   dmem_access_ctrl #(.ADDR_W(32)) dut (
`endif
      .clk(clk), .cpu_rst_n(cpu_rst_n),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_stall(mem_stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .misalign(misalign), .access_cnt(access_cnt)
`ifdef DMEM_TIMEOUT_EN
      , .bus_timeout(bus_timeout)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   initial begin
      cpu_rst_n = 1'b0;
      mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
      bus_ack = 1'b0; bus_rdata = 32'h0;
      #1;
      chk("rst_stall_with_req", mem_stall, 1'b0);
      step(); step();
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_mem_din", mem_din, 32'h0);
      chk("rst_misalign", misalign, 1'b0);
      chk("rst_access_cnt", access_cnt, 32'h0);
      mem_ren = 1'b0;
      cpu_rst_n = 1'b1;
      step();
      chk("idle_no_req_stall", mem_stall, 1'b0);

      // Zero-wait read at 0x10
      mem_ren = 1'b1; mem_addr = 32'h0000_0010;
      #1;
      chk("rd0_stall_c1", mem_stall, 1'b1);
      step();
      chk("rd0_bus_req", bus_req, 1'b1);
      chk("rd0_bus_addr", bus_addr, 32'h10);
      chk("rd0_bus_we", bus_we, 1'b0);
      chk("rd0_stall_c2", mem_stall, 1'b1);
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      step();
      bus_ack = 1'b0; bus_rdata = 32'h0;
      chk("rd0_stall_done", mem_stall, 1'b0);
      chk("rd0_mem_din", mem_din, 32'h1234_5678);
      chk("rd0_access_cnt", access_cnt, 32'd1);
      chk("rd0_req_dropped", bus_req, 1'b0);
      mem_ren = 1'b0;
      step();
      chk("rd0_idle_stall", mem_stall, 1'b0);
      chk("rd0_idle_req", bus_req, 1'b0);

      // Write with ack on the third request cycle; inputs scrambled while busy
      mem_wen = 1'b1; mem_addr = 32'h0000_0020; mem_dout = 32'hCAFE_F00D;
      #1;
      chk("wr3_stall_c1", mem_stall, 1'b1);
      step();
      mem_addr = 32'hFFFF_FFF0; mem_dout = 32'h0BAD_0BAD;
      for (int i = 0; i < 3; i++) begin
         chk("wr3_bus_req", bus_req, 1'b1);
         chk("wr3_bus_we", bus_we, 1'b1);
         chk("wr3_bus_addr", bus_addr, 32'h20);
         chk("wr3_bus_wdata", bus_wdata, 32'hCAFE_F00D);
         chk("wr3_stall_busy", mem_stall, 1'b1);
         if (i == 2) begin
            bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
         end
         step();
      end
      bus_ack = 1'b0;
      chk("wr3_stall_done", mem_stall, 1'b0);
      chk("wr3_mem_din_kept", mem_din, 32'h1234_5678);
      chk("wr3_access_cnt", access_cnt, 32'd2);
      mem_wen = 1'b0;
      step();

      // Misaligned read at 0x13
      mem_ren = 1'b1; mem_addr = 32'h0000_0013;
      #1;
      chk("mis_not_yet", misalign, 1'b0);
      step();
      chk("mis_bus_addr", bus_addr, 32'h10);
      chk("mis_flag", misalign, 1'b1);
      bus_ack = 1'b1; bus_rdata = 32'hA5A5_0001;
      step();
      bus_ack = 1'b0;
      chk("mis_mem_din", mem_din, 32'hA5A5_0001);
      // Back-to-back: next aligned request presented during DONE, taken in IDLE
      mem_addr = 32'h0000_0024;
      step();
      chk("b2b_idle_req", bus_req, 1'b0);
      chk("b2b_idle_stall", mem_stall, 1'b1);
      step();
      chk("b2b_bus_addr", bus_addr, 32'h24);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      step();
      bus_ack = 1'b0;
      chk("b2b_mem_din", mem_din, 32'h0BAD_F00D);
      chk("mis_sticky", misalign, 1'b1);
      chk("b2b_access_cnt", access_cnt, 32'd4);
      mem_ren = 1'b0;
      step();

      // Read and write together: write wins, read data returned as zero
      mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h0000_0040; mem_dout = 32'h1111_2222;
      step();
      chk("both_bus_we", bus_we, 1'b1);
      chk("both_bus_addr", bus_addr, 32'h40);
      chk("both_bus_wdata", bus_wdata, 32'h1111_2222);
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_ack = 1'b0;
      chk("both_mem_din_zero", mem_din, 32'h0);
      chk("both_access_cnt", access_cnt, 32'd5);
      mem_ren = 1'b0; mem_wen = 1'b0;
      step();
      // Spurious ack in IDLE
      bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      step();
      bus_ack = 1'b0;
      chk("spur_access_cnt", access_cnt, 32'd5);
      chk("spur_bus_req", bus_req, 1'b0);
      chk("spur_mem_din", mem_din, 32'h0);
      chk("spur_stall", mem_stall, 1'b0);

      // Reset in BUSY, late ack after release
      mem_ren = 1'b1; mem_addr = 32'h0000_0050;
      step();
      chk("rb_busy_req", bus_req, 1'b1);
      cpu_rst_n = 1'b0;
      #1;
      chk("rb_req_now", bus_req, 1'b0);
      chk("rb_stall_now", mem_stall, 1'b0);
      chk("rb_cnt_now", access_cnt, 32'd0);
      chk("rb_din_now", mem_din, 32'h0);
      chk("rb_misalign_now", misalign, 1'b0);
      mem_ren = 1'b0;
      step();
      cpu_rst_n = 1'b1;
      step();
      bus_ack = 1'b1; bus_rdata = 32'h9999_0000;
      step();
      bus_ack = 1'b0;
      chk("rb_late_cnt", access_cnt, 32'd0);
      chk("rb_late_din", mem_din, 32'h0);
      chk("rb_late_req", bus_req, 1'b0);
      chk("rb_late_stall", mem_stall, 1'b0);

`ifdef DMEM_TIMEOUT_EN
      // Read with no ack: abort after 4 BUSY cycles
      mem_ren = 1'b1; mem_addr = 32'h0000_0060;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("to_req_held", bus_req, 1'b1);
         step();
      end
      chk("to_req_dropped", bus_req, 1'b0);
      chk("to_mem_din", mem_din, 32'hDEAD_BEEF);
      chk("to_flag", bus_timeout, 1'b1);
      chk("to_access_cnt", access_cnt, 32'd0);
      chk("to_stall_done", mem_stall, 1'b0);
      mem_ren = 1'b0;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
